regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, >=2); AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port ready  out  1  high once the init sweep has completed.
REQ-009 SHALL have port raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-010 SHALL have port rdata  out  NRD*XLEN  read data, packed the same way as raddr.
REQ-011 SHALL have port rbusy  out  NRD  per read port, source register has a pending write.
REQ-012 SHALL have port we  in  NWR  per-port write enable, active-high.
REQ-013 SHALL have port waddr  in  NWR*AW  write addresses.
REQ-014 SHALL have port wdata  in  NWR*XLEN  write data.
REQ-015 SHALL have port bset  in  1  scoreboard set request.
REQ-016 SHALL have port bset_addr  in  AW  register to mark busy.

Function
REQ-017 SHALL implement a two-state FSM: INIT and RUN.
REQ-018 INIT: counter cnt clears rf[cnt] and busy[cnt] each cycle, then cnt+1; after cnt==NREG-1 is cleared, the next state SHALL be RUN.
REQ-019 ready SHALL be 1 only in RUN; first ready=1 SHALL occur NREG rising edges after the first edge with rst=0.
REQ-020 In INIT, we and bset SHALL be ignored, all rdata SHALL be 0 and all rbusy SHALL be 0.
REQ-021 In RUN, a write with we[j]=1 and waddr!=0 SHALL update rf[waddr] on the edge; writes to r0 SHALL be discarded.
REQ-022 If two write ports target the same nonzero address in one cycle, the higher-index port SHALL win.
REQ-023 Reads SHALL be combinational; raddr==0 SHALL return 0 and rbusy=0.
REQ-024 With BYPASS=1, a read SHALL return the write data of the highest-index port that has we=1 and matching nonzero waddr in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-025 A write commit (we[j]=1, waddr!=0) SHALL clear busy[waddr] on the edge.
REQ-026 bset=1 with bset_addr!=0 SHALL set busy[bset_addr] on the edge; bset_addr==0 SHALL be ignored.
REQ-027 Same-cycle set and clear of one address SHALL leave busy=1 (set wins; a new producer is pending).
REQ-028 rbusy[i] SHALL equal busy[raddr_i], except with BYPASS=1 it SHALL be 0 when a same-cycle write to raddr_i is being forwarded.
REQ-029 Register contents SHALL be exactly XLEN bits; there are no width extensions or truncations.

Reset
REQ-030 rst=1 on an edge SHALL force state INIT, cnt=0 and ready=0, and SHALL abandon any sweep or writes in progress; register contents SHALL NOT change on that edge.
REQ-031 While rst is held, cnt SHALL stay 0 and no register SHALL be cleared; the sweep SHALL start on the first edge with rst=0.
REQ-032 rst asserted in RUN SHALL restart the full NREG-cycle sweep; all registers SHALL read 0 afterwards.

Verification
REQ-033 Reset sweep: rst=1 for 3 cycles, then 0 -> ready=0 for exactly 32 edges and 1 on the 32nd; then read r1..r31 -> all return 0, rbusy=0.
REQ-034 Write/read: we[0]=1, waddr0=5, wdata0=0xDEADBEEF, raddr0=5 in the same cycle -> rdata0=0xDEADBEEF (bypass); next cycle with we=0 -> still 0xDEADBEEF; BYPASS=0 build -> old value 0 in the write cycle.
REQ-035 Port conflict and r0: we=2'b11, waddr0=waddr1=7, wdata0=0x1, wdata1=0x2 -> r7=0x2; write 0xFFFFFFFF to r0 -> r0 reads 0.
REQ-036 Scoreboard: bset, bset_addr=9 -> rbusy for raddr=9 is 1; a later write to r9 gives rbusy=0 in that cycle (BYPASS=1) and 0 afterwards; same-cycle bset=9 and write r9 -> busy stays 1.
REQ-037 Reset mid-sweep and mid-run: rst pulse at cnt=10 -> sweep restarts from 0, ready after 32 more edges; rst in RUN after r3=0x55 -> ready drops, r3 reads 0 after re-init, writes during INIT have no effect.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with init sweep, write forwarding
// and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic              bset,
  input  logic [AW-1:0]     bset_addr
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [AW-1:0]   ra;
  logic [AW-1:0]   wa;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;
      end
      default: state_d = INIT;
    endcase
  end

  assign ready = (state_q == RUN);

  // Higher-index write ports are visited last, so they win conflicts;
  // a scoreboard set is applied after the clears so it wins too.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        rf[cnt_q]   <= '0;
        busy[cnt_q] <= 1'b0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (waddr[j*AW +: AW] != '0)) begin
            rf[waddr[j*AW +: AW]]   <= wdata[j*XLEN +: XLEN];
            busy[waddr[j*AW +: AW]] <= 1'b0;
          end
        end
        if (bset && (bset_addr != '0)) busy[bset_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    wa    = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = raddr[i*AW +: AW];
      if (ready && (ra != '0)) begin
        rdata[i*XLEN +: XLEN] = rf[ra];
        rbusy[i]              = busy[ra];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            wa = waddr[j*AW +: AW];
            if (we[j] && (wa == ra)) begin
              rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
              rbusy[i]              = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule
